cpu_trace_monitor: RTL and testbench

- Synthesizable run monitor that sits beside TopLevel and observes its clk/reset/start/done, PC and instruction buses.
- Counts cycles from start to done and enforces a parametrised watchdog limit.
- Records the last DEPTH executed {cycle, PC, instruction} entries in a circular trace buffer.
- After the run ends, the trace drains oldest-first through a valid/ready port, so the bench or a debug UART needs no hierarchical peeking.

---
 rtl/cpu_trace_pkg.sv | 29 ++
 rtl/trace_ring_buf.sv | 76 +++++++
 rtl/cpu_trace_monitor.sv | 177 +++++++++++++++++
 tb/tb_cpu_trace_monitor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types and default constants for the CPU run/trace monitor.
package cpu_trace_pkg;

  localparam int unsigned DEF_PC_W    = 10;
  localparam int unsigned DEF_INSTR_W = 9;
  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_DEPTH   = 16;
  localparam int unsigned DEF_TIMEOUT = 1000;

  localparam int unsigned ENT_CYCLE_W = DEF_CNT_W;
  localparam int unsigned ENT_PC_W    = DEF_PC_W;
  localparam int unsigned ENT_INSTR_W = DEF_INSTR_W;
  localparam int unsigned ENT_W       = ENT_CYCLE_W + ENT_PC_W + ENT_INSTR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  // Field order matches the packed word stored in the trace ring.
  typedef struct packed {
    logic [ENT_CYCLE_W-1:0] cycle;
    logic [ENT_PC_W-1:0]    pc;
    logic [ENT_INSTR_W-1:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/trace_ring_buf.sv
// Circular trace RAM: push with overwrite-on-full, pop from the head, occupancy
// count and a sticky overflow flag. clr_i has priority over push and pop.
module trace_ring_buf
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned W     = ENT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [W-1:0]             head_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] head_idx;
  logic             full;

  assign full = (count_q == FULL_CNT);
  // DEPTH is a power of two, so the low pointer bits give the mod-DEPTH head.
  assign head_idx = wr_ptr_q - count_q[PTR_W-1:0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr_i) begin
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (push_i) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (pop_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign head_data_o = mem_q[head_idx];

endmodule

// File: rtl/cpu_trace_monitor.sv
// Run monitor: start-to-done cycle counter, watchdog, and a drainable trace of
// the last DEPTH {cycle, pc, instr} entries. Optional macro: TRACE_DEDUP_EN.
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               done,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic               busy,
  output logic               halted,
  output logic               timed_out,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [PC_W-1:0]    end_pc,
  output logic               overflow,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [CNT_W-1:0]   rd_cycle,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [1:0]         dbg_state_o
);

  localparam int unsigned W     = CNT_W + PC_W + INSTR_W;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, cnt_inc;
  logic [PC_W-1:0]  end_pc_q, end_pc_d;
  logic             halted_q, halted_d;
  logic             timed_out_q, timed_out_d;
  logic             to_hit;

  logic             in_run, in_drain, run_start, wr_en;
  logic             rb_clr, rb_push, rb_pop;
  logic [CW-1:0]    rb_count;
  logic             rb_overflow;
  logic [W-1:0]     rb_head;
  logic [CNT_W-1:0] head_cycle;
  logic [PC_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;

  assign cnt_inc = cycle_cnt_q + 1'b1;
  // The watchdog compares the value being reached, so cycle_cnt stops at TIMEOUT.
  assign to_hit  = (cnt_inc == TO_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, cpu_trace_pkg::TIMEOUT: if (start) state_d = RUN;
      RUN: begin
        if (done) begin
          state_d = DONE;
        end else if (to_hit) begin
          state_d = cpu_trace_pkg::TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drain handshake: rd_valid/rd_* depend only on state, never on rd_ready; an
  // entry transfers on a cycle with rd_valid && rd_ready, and start on that
  // same cycle cancels the transfer and discards the trace.
  always_comb begin
    in_run    = (state_q == RUN);
    in_drain  = (state_q == DONE) || (state_q == cpu_trace_pkg::TIMEOUT);
    run_start = start && !in_run;
    busy      = in_run;
    rd_valid  = in_drain && (rb_count != '0);
    rb_clr    = run_start;
    rb_push   = in_run && wr_en;
    rb_pop    = rd_valid && rd_ready && !start;
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    end_pc_d    = end_pc_q;
    halted_d    = halted_q;
    timed_out_d = timed_out_q;
    if (run_start) begin
      cycle_cnt_d = '0;
      halted_d    = 1'b0;
      timed_out_d = 1'b0;
    end else if (in_run) begin
      cycle_cnt_d = cnt_inc;
      if (done) begin
        halted_d = 1'b1;
        end_pc_d = pc;
      end else if (to_hit) begin
        timed_out_d = 1'b1;
        end_pc_d    = pc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      end_pc_q    <= '0;
      halted_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      end_pc_q    <= end_pc_d;
      halted_q    <= halted_d;
      timed_out_q <= timed_out_d;
    end
  end

`ifdef TRACE_DEDUP_EN
  logic [PC_W-1:0] last_pc_q;
  logic            first_q;

  // A stall on one PC is recorded once; later timestamps show its length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pc_q <= '0;
      first_q   <= 1'b1;
    end else if (run_start) begin
      first_q <= 1'b1;
    end else if (rb_push) begin
      first_q   <= 1'b0;
      last_pc_q <= pc;
    end
  end

  assign wr_en = first_q || (pc != last_pc_q);
`else
  assign wr_en = 1'b1;
`endif

  trace_ring_buf #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_ring (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (rb_clr),
    .push_i      (rb_push),
    .push_data_i ({cnt_inc, pc, instr}),
    .pop_i       (rb_pop),
    .count_o     (rb_count),
    .overflow_o  (rb_overflow),
    .head_data_o (rb_head)
  );

  assign {head_cycle, head_pc, head_instr} = rb_head;

  assign rd_cycle    = rd_valid ? head_cycle : '0;
  assign rd_pc       = rd_valid ? head_pc    : '0;
  assign rd_instr    = rd_valid ? head_instr : '0;
  assign halted      = halted_q;
  assign timed_out   = timed_out_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign end_pc      = end_pc_q;
  assign overflow    = rb_overflow;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor: table of run scenarios, randomized
// runs against a queue model, and hand-written restart/reset/stall sequences.
module tb_cpu_trace_monitor;

  localparam int PC_W      = 10;
  localparam int INSTR_W   = 9;
  localparam int CNT_W     = 16;
  localparam int DEPTH_C   = 16;
  localparam int TIMEOUT_C = 1000;
  localparam int ENT_W     = CNT_W + PC_W + INSTR_W;
`ifdef TRACE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic               clk, reset, start, done, rd_ready;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic               busy, halted, timed_out, overflow, rd_valid;
  logic [CNT_W-1:0]   cycle_cnt, rd_cycle;
  logic [PC_W-1:0]    end_pc, rd_pc;
  logic [INSTR_W-1:0] rd_instr;
  logic [1:0]         dbg_state;

  cpu_trace_monitor #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .DEPTH(DEPTH_C), .TIMEOUT(TIMEOUT_C)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .pc(pc), .instr(instr),
    .busy(busy), .halted(halted), .timed_out(timed_out), .cycle_cnt(cycle_cnt),
    .end_pc(end_pc), .overflow(overflow), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_cycle(rd_cycle), .rd_pc(rd_pc), .rd_instr(rd_instr), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  // scoreboard
  logic [ENT_W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  bit m_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_timed_out"}, timed_out, 0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 0);
    check({tag, "_end_pc"}, end_pc, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, {rd_cycle, rd_pc, rd_instr}, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // drivers
  task automatic start_pulse();
    start = 1'b1;
    done  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_cycle_cnt", cycle_cnt, 0);
    check("start_flags", {halted, timed_out, overflow, rd_valid}, 0);
  endtask

  logic [PC_W-1:0] stall_pc [7];

  // Drives RUN cycles until done_at or the watchdog; the model pushes entries.
  task automatic run_body(input int done_at, input int pc_mode, input bit rand_start,
                          output int n_cyc, output bit ended_done,
                          output logic [PC_W-1:0] last_pc);
    bit m_first;
    logic [PC_W-1:0] m_last_pc;
    logic [ENT_W-1:0] dummy;
    exp_q.delete();
    m_ovf = 1'b0;
    m_first = 1'b1;
    m_last_pc = '0;
    n_cyc = 0;
    ended_done = 1'b0;
    last_pc = '0;
    for (int k = 1; k <= TIMEOUT_C; k++) begin
      case (pc_mode)
        0:       pc = PC_W'(k - 1);
        1:       pc = PC_W'($urandom_range(0, 3));
        default: pc = stall_pc[(k - 1) % 7];
      endcase
      instr = INSTR_W'($urandom);
      done  = (k == done_at);
      start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      n_cyc = k;
      last_pc = pc;
      if (!DEDUP || m_first || (pc != m_last_pc)) begin
        exp_q.push_back({CNT_W'(k), pc, instr});
        m_first = 1'b0;
        m_last_pc = pc;
        if (exp_q.size() > DEPTH_C) begin
          dummy = exp_q.pop_front();
          m_ovf = 1'b1;
        end
      end
      if (k == done_at) begin
        ended_done = 1'b1;
        break;
      end
      if (k == TIMEOUT_C) break;
    end
    done  = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_end(input int n_cyc, input bit ended_done, input logic [PC_W-1:0] lpc);
    check("end_busy", busy, 0);
    check("end_halted", halted, ended_done);
    check("end_timed_out", timed_out, !ended_done);
    check("end_cycle_cnt", cycle_cnt, n_cyc);
    check("end_pc", end_pc, lpc);
    check("end_overflow", overflow, m_ovf);
    check("end_state", dbg_state, ended_done ? 2 : 3);
  endtask

  // Pops up to max_pops entries, comparing each against the model queue.
  task automatic drain(input int mode, input int max_pops, output int n_got, output int first_cyc);
    bit rdy, v;
    logic [ENT_W-1:0] got, dummy;
    n_got = 0;
    first_cyc = -1;
    for (int c = 0; c < 8 * DEPTH_C + 8; c++) begin
      if (exp_q.size() == 0 || n_got == max_pops) break;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rd_ready = rdy;
      #1;
      v = rd_valid;
      got = {rd_cycle, rd_pc, rd_instr};
      check("drain_valid", v, 1);
      if (v) check("drain_entry", got, exp_q[0]);
      @(posedge clk); #1;
      if (v && rdy) begin
        if (n_got == 0) first_cyc = int'(got[ENT_W-1 -: CNT_W]);
        n_got++;
        dummy = exp_q.pop_front();
      end
    end
    rd_ready = 1'b0;
    if (exp_q.size() != 0 && n_got != max_pops)
      check("drain_bound_expired", exp_q.size(), 0);
    if (max_pops > DEPTH_C) begin
      #1;
      check("drain_empty_valid", rd_valid, 0);
    end
  endtask

  typedef struct {
    int done_at;      // 0 = never assert done
    int rdy_mode;
    bit exp_halted;
    bit exp_to;
    int exp_cnt;
    bit exp_ovf;
    int exp_n;
    int exp_first;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n_cyc, n_got, first_cyc;
    bit ended;
    logic [PC_W-1:0] lpc;

    vecs[0] = '{5,    0, 1, 0, 5,    0, 5,  1};
    vecs[1] = '{20,   0, 1, 0, 20,   1, 16, 5};
    vecs[2] = '{16,   1, 1, 0, 16,   0, 16, 1};
    vecs[3] = '{17,   2, 1, 0, 17,   1, 16, 2};
    vecs[4] = '{1,    2, 1, 0, 1,    0, 1,  1};
    vecs[5] = '{0,    2, 0, 1, 1000, 1, 16, 985};
    vecs[6] = '{1000, 0, 1, 0, 1000, 1, 16, 985};
    stall_pc[0] = 10'd0; stall_pc[1] = 10'd1; stall_pc[2] = 10'd3; stall_pc[3] = 10'd3;
    stall_pc[4] = 10'd3; stall_pc[5] = 10'd3; stall_pc[6] = 10'd4;

    reset = 1'b1; start = 1'b0; done = 1'b0; rd_ready = 1'b0;
    pc = '0; instr = '0;
    #1;
    check_idle_zero("reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    rd_ready = 1'b1;
    #1;
    check("idle_rd_valid", rd_valid, 0);
    rd_ready = 1'b0;

    // table-driven runs, sequential pc so expectations hold with or without dedup
    for (int i = 0; i < 7; i++) begin
      start_pulse();
      run_body(vecs[i].done_at, 0, 1'b0, n_cyc, ended, lpc);
      check("vec_halted", halted, vecs[i].exp_halted);
      check("vec_timed_out", timed_out, vecs[i].exp_to);
      check("vec_cycle_cnt", cycle_cnt, vecs[i].exp_cnt);
      check("vec_end_pc", end_pc, vecs[i].exp_cnt - 1);
      check("vec_overflow", overflow, vecs[i].exp_ovf);
      check_end(n_cyc, ended, lpc);
      drain(vecs[i].rdy_mode, 1000, n_got, first_cyc);
      check("vec_n_drained", n_got, vecs[i].exp_n);
      check("vec_first_cycle", first_cyc, vecs[i].exp_first);
    end

    // randomized runs with repeating pcs and start noise while running
    for (int r = 0; r < 6; r++) begin
      start_pulse();
      run_body($urandom_range(1, 40), 1, 1'b1, n_cyc, ended, lpc);
      check_end(n_cyc, ended, lpc);
      drain(2, 1000, n_got, first_cyc);
    end

    // restart mid-drain: remaining entries discarded, no transfer that cycle
    start_pulse();
    run_body(5, 0, 1'b0, n_cyc, ended, lpc);
    drain(0, 2, n_got, first_cyc);
    check("restart_pre_pops", n_got, 2);
    start = 1'b1;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_rd_valid", rd_valid, 0);
    check("restart_cycle_cnt", cycle_cnt, 0);
    check("restart_busy", busy, 1);
    run_body(3, 0, 1'b0, n_cyc, ended, lpc);
    check_end(n_cyc, ended, lpc);
    drain(0, 1000, n_got, first_cyc);
    check("restart_n", n_got, 3);
    check("restart_first", first_cyc, 1);

    // stall on pc 3 for four cycles
    start_pulse();
    run_body(7, 2, 1'b0, n_cyc, ended, lpc);
    check_end(n_cyc, ended, lpc);
    drain(1, 1000, n_got, first_cyc);
    check("stall_n_entries", n_got, DEDUP ? 4 : 7);

    // reset mid-run at cycle 7
    start_pulse();
    for (int k = 1; k <= 7; k++) begin
      pc = PC_W'(k + 100);
      instr = INSTR_W'($urandom);
      @(posedge clk); #1;
    end
    check("midrun_cycle_cnt", cycle_cnt, 7);
    check("midrun_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check_idle_zero("midrun_reset");
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_state", dbg_state, 0);
    check("post_reset_valid", rd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
